pwm_demodulator: RTL and testbench
==================================

# pwm_demodulator

Receive-side counterpart of the PWM generator. Takes a PWM waveform from a pin or an upstream generator, filters it, and measures period and high time between rising edges. Converts the duty cycle back into a `Size`-bit data word with a sequential restoring divider, and flags loss of signal and out-of-range periods. Its `Data` output feeds the existing 7-segment display path directly, which closes the loop PWM → number → display.

## Interface
- `Size`, 5: output data width; same meaning as in the generator.
- `ClockPeriod_ns`, 20: `Clock` period.
- `PWMPeriod_ns`, 200_000: nominal PWM period.
  - `PeriodTicks = PWMPeriod_ns/ClockPeriod_ns`.
- `FilterCycles`, 3: number of consecutive equal synchronized samples required to accept a new input level.
- `Signed`, "No": `"No"` or `"Yes"`.
  - `PWMDSize = (Signed=="No") ? Size : Size-1`.
  - `FullScale = 2**PWMDSize - 1`.

- `Clock`  in  1  system clock; all state on the rising edge.
- `Reset_n`  in  1  asynchronous, active-low reset.
- `PWM`  in  1  asynchronous PWM input.
- `Sign`  in  1  sign of the value; used only when `Signed=="Yes"`.
- `Data`  out  `Size`  last decoded value.
  - Unsigned magnitude when `Signed=="No"`.
  - Two's complement when `Signed=="Yes"`.
- `Valid`  out  1  one-cycle pulse when `Data` updates.
- `Timeout`  out  1  one-cycle pulse on loss of edges.
- `Error`  out  1  one-cycle pulse when a period is rejected.

## Operation
- Input conditioning:
  - `PWM` and `Sign` each pass through a 2-FF synchronizer.
  - Filtered level `F` changes only after `FilterCycles` equal consecutive synchronized samples.
  - A rise of `F` is an edge event `E`. `Sign` is sampled at `E`.
- Counters, width `CW = $clog2(2*PeriodTicks+2)`, both saturating:
  - `PerCnt` is set to 1 at `E` and otherwise increments.
  - `HiCnt` is set to 1 at `E` and otherwise increments while `F=1`.
- Measurement FSM states are `WAIT_EDGE` and `MEASURE`.
  - Reset enters `WAIT_EDGE`.
  - In `WAIT_EDGE`, the first `E` clears the counters, goes to `MEASURE`, and produces no result.
  - In `MEASURE`, at each `E` the pre-edge `PerCnt` (P) and `HiCnt` (H) are latched.
    - If `PeriodTicks/2 <= P <= 3*PeriodTicks/2`, the divider starts.
    - Otherwise `Error` pulses, `Data` holds, and the FSM stays in `MEASURE`.
  - In either state, when `PerCnt` reaches `2*PeriodTicks` without an edge:
    - `Timeout` and `Valid` pulse.
    - Magnitude becomes `FullScale` if `F=1`, else 0.
    - The FSM goes to `WAIT_EDGE`.
    - Any running division is aborted and its result discarded.
- Divider FSM states are `D_IDLE`, `D_RUN` and `D_DONE`.
  - Numerator `N = H*FullScale + P/2`, width `CW+PWMDSize`. Denominator is `P`.
  - Restoring division produces one quotient bit per cycle, MSB first, over `PWMDSize` cycles.
  - Because H ≤ P, the quotient is ≤ `FullScale`. It is still saturated to `FullScale` as a guard.
  - An `E` arriving while the divider is in `D_RUN` is impossible in-range, since P ≥ `PeriodTicks/2` is far greater than `PWMDSize`. An out-of-range short period is rejected before division.
- Output formatting:
  - `Signed=="No"`: `Data = mag`.
  - `Signed=="Yes"`: `Data = Sign ? -{1'b0,mag} : {1'b0,mag}` in `Size` bits. −0 maps to 0.
- Simultaneous events: timeout and a division finishing in the same cycle resolve to the timeout result.

## Timing
- Reset values:
  - `Data=0`, `Valid=0`, `Timeout=0`, `Error=0`.
  - Both FSMs idle, counters 0, synchronizers and filter 0.
- Input to `F` latency: 2 + `FilterCycles` cycles (5 at default).
- With `E` registered in cycle c:
  - Operands load in c+1.
  - The divider runs in c+1 … c+`PWMDSize`.
  - `D_DONE` is in c+`PWMDSize`+1, where `Data` updates and `Valid=1` for exactly one cycle.
  - At `Size=5` unsigned, the result appears 6 cycles after `E`.
- `Error` asserts in c+1. `Timeout` asserts the cycle after `PerCnt` reaches the limit.
- `Reset_n` low mid-operation immediately forces all reset values, including aborting the divider with no `Valid`.

## Test plan
- 50% duty: `Size`=5 unsigned, P=10000, H=5000, several periods → first edge gives no `Valid`; afterwards `Data`=16 and one `Valid` pulse per period, 6 cycles after `E`.
- 25% duty: H=2500 → `Data`=8. H=10000−1 → `Data`=31. H at the minimum filtered width → `Data`=0.
- Loss of signal: hold `PWM` high for 25000 cycles → `Timeout` and `Valid` pulse once, `Data`=31, FSM in `WAIT_EDGE`. Repeat held low → `Data`=0.
- Bad period: P=4000 → `Error` pulse, no `Valid`, `Data` unchanged. Glitches of 1–2 cycles → ignored, `Data` unchanged.
- Signed: `Size`=5, `Signed`="Yes", H=5000, `Sign`=1 → `Data`=5'b11000 (−8). With `Sign`=0 → `Data`=8.
- Reset: assert `Reset_n`=0 during `D_RUN` → all outputs 0 at once, no `Valid`. After release, the first edge produces no result and the second edge produces the correct result.

Source files
------------

// File: rtl/pwm_demodulator.sv
// PWM receiver: conditions the input, measures period and high time between
// rising edges and turns the duty cycle back into a Size-bit word.
module pwm_demodulator #(
  parameter int    Size           = 5,
  parameter int    ClockPeriod_ns = 20,
  parameter int    PWMPeriod_ns   = 200_000,
  parameter int    FilterCycles   = 3,
  parameter string Signed         = "No"
) (
  input  logic            Clock,
  input  logic            Reset_n,
  input  logic            PWM,
  input  logic            Sign,
  output logic [Size-1:0] Data,
  output logic            Valid,
  output logic            Timeout,
  output logic            Error
);

  localparam int PeriodTicks = PWMPeriod_ns / ClockPeriod_ns;
  localparam bit IsSigned    = (Signed == "Yes");
  localparam int PWMDSize    = IsSigned ? Size - 1 : Size;
  localparam int FullScale   = 2**PWMDSize - 1;
  localparam int CW          = $clog2(2*PeriodTicks + 2);
  localparam int NW          = CW + PWMDSize;
  localparam int FW          = $clog2(FilterCycles + 1);
  localparam int BW          = $clog2(PWMDSize + 1);

  localparam logic [CW-1:0]       CntMax = '1;
  localparam logic [CW-1:0]       Limit  = CW'(2*PeriodTicks);
  localparam logic [CW-1:0]       PerMin = CW'(PeriodTicks/2);
  localparam logic [CW-1:0]       PerMax = CW'(3*PeriodTicks/2);
  localparam logic [PWMDSize-1:0] FsMag  = PWMDSize'(FullScale);

  typedef enum logic {WAIT_EDGE, MEASURE} meas_state_t;
  typedef enum logic [1:0] {D_IDLE, D_RUN, D_DONE} div_state_t;

  logic              pwm_p0, pwm_p1, sign_p0, sign_p1;
  logic              filt, filt_q, rise;
  logic [FW-1:0]     flt_cnt;
  logic [CW-1:0]     per_cnt, hi_cnt;
  logic              tmo_hit, in_range, start, reject;
  meas_state_t       meas_state, meas_next;
  div_state_t        div_state, div_next;
  logic [BW-1:0]     bit_cnt;
  logic              bit_last, div_step, div_finish;
  logic              sign_lat;
  logic [NW-1:0]     numer;
  logic [CW-1:0]     rem_p1, den_p1;
  logic [PWMDSize-1:0] num_p1, quo_p1, quo_next;
  logic              ovf_p1;
  logic [CW:0]       shifted;
  logic              q_bit;

  // H <= P keeps the quotient in range; the overflow flag is only a guard.
  function automatic logic [PWMDSize-1:0] sat_mag(input logic [PWMDSize-1:0] q,
                                                   input logic ovf);
    return ovf ? FsMag : q;
  endfunction

  function automatic logic [Size-1:0] fmt_data(input logic [PWMDSize-1:0] mag,
                                               input logic sgn);
    logic signed [Size-1:0] ext;
    ext = Size'(mag);
    if (IsSigned && sgn) ext = -ext;
    return ext;
  endfunction

  // Stage p0/p1: two-flop synchronizers, then the level filter
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      pwm_p0  <= 1'b0;
      pwm_p1  <= 1'b0;
      sign_p0 <= 1'b0;
      sign_p1 <= 1'b0;
      filt    <= 1'b0;
      filt_q  <= 1'b0;
      flt_cnt <= '0;
    end else begin
      pwm_p0  <= PWM;
      pwm_p1  <= pwm_p0;
      sign_p0 <= Sign;
      sign_p1 <= sign_p0;
      filt_q  <= filt;
      if (pwm_p1 == filt) begin
        flt_cnt <= '0;
      end else if (flt_cnt == FW'(FilterCycles - 1)) begin
        filt    <= pwm_p1;
        flt_cnt <= '0;
      end else begin
        flt_cnt <= flt_cnt + FW'(1);
      end
    end
  end

  assign rise = filt & ~filt_q;

  // Period and high-time counters, restarted by every filtered rising edge
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      per_cnt  <= '0;
      hi_cnt   <= '0;
      sign_lat <= 1'b0;
    end else if (rise) begin
      per_cnt  <= CW'(1);
      hi_cnt   <= CW'(1);
      sign_lat <= sign_p1;
    end else begin
      if (per_cnt != CntMax) per_cnt <= per_cnt + CW'(1);
      if (filt && hi_cnt != CntMax) hi_cnt <= hi_cnt + CW'(1);
    end
  end

  assign tmo_hit  = (per_cnt == Limit) && !rise;
  assign in_range = (per_cnt >= PerMin) && (per_cnt <= PerMax);

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) meas_state <= WAIT_EDGE;
    else          meas_state <= meas_next;
  end

  always_comb begin
    meas_next = meas_state;
    case (meas_state)
      WAIT_EDGE: if (rise)    meas_next = MEASURE;
      MEASURE:   if (tmo_hit) meas_next = WAIT_EDGE;
      default:                meas_next = WAIT_EDGE;
    endcase
  end

  always_comb begin
    start  = (meas_state == MEASURE) && rise && in_range;
    reject = (meas_state == MEASURE) && rise && !in_range;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) div_state <= D_IDLE;
    else          div_state <= div_next;
  end

  always_comb begin
    div_next = div_state;
    case (div_state)
      D_IDLE: if (start) div_next = D_RUN;
      D_RUN: begin
        if (tmo_hit)       div_next = D_IDLE;
        else if (start)    div_next = D_RUN;
        else if (bit_last) div_next = D_DONE;
      end
      D_DONE:  div_next = start ? D_RUN : D_IDLE;
      default: div_next = D_IDLE;
    endcase
  end

  always_comb begin
    bit_last   = (bit_cnt == BW'(PWMDSize - 1));
    div_step   = (div_state == D_RUN);
    div_finish = (div_state == D_RUN) && bit_last && !tmo_hit && !start;
  end

  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n)      bit_cnt <= '0;
    else if (start)    bit_cnt <= '0;
    else if (div_step) bit_cnt <= bit_cnt + BW'(1);
  end

  // Rounded numerator: H*FullScale + P/2, divided by P
  assign numer    = NW'(hi_cnt) * NW'(FullScale) + NW'(per_cnt >> 1);
  assign shifted  = {rem_p1, num_p1[PWMDSize-1]};
  assign q_bit    = (shifted >= {1'b0, den_p1});
  assign quo_next = PWMDSize'({quo_p1, q_bit});

  // Stage p1: restoring divider, one quotient bit per cycle, MSB first
  always_ff @(posedge Clock) begin
    if (start) begin
      rem_p1 <= numer[NW-1:PWMDSize];
      num_p1 <= numer[PWMDSize-1:0];
      den_p1 <= per_cnt;
      quo_p1 <= '0;
      ovf_p1 <= (numer[NW-1:PWMDSize] >= per_cnt);
    end else if (div_step) begin
      rem_p1 <= q_bit ? CW'(shifted - {1'b0, den_p1}) : CW'(shifted);
      num_p1 <= num_p1 << 1;
      quo_p1 <= quo_next;
    end
  end

  // Stage p2: output register; a timeout overrides a finishing division
  always_ff @(posedge Clock or negedge Reset_n) begin
    if (!Reset_n) begin
      Data    <= '0;
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      Error   <= 1'b0;
    end else begin
      Valid   <= 1'b0;
      Timeout <= 1'b0;
      Error   <= reject;
      if (tmo_hit) begin
        Data    <= fmt_data(filt ? FsMag : '0, sign_lat);
        Valid   <= 1'b1;
        Timeout <= 1'b1;
      end else if (div_finish) begin
        Data  <= fmt_data(sat_mag(quo_next, ovf_p1), sign_lat);
        Valid <= 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_pwm_demodulator.sv
// Directed bench for pwm_demodulator: unsigned and signed instances share one
// PWM stream with a 500-cycle nominal period (10 us at a 20 ns clock).
module tb_pwm_demodulator;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       pwm = 1'b0;
  logic       sgn = 1'b0;
  logic [4:0] data_u, data_s;
  logic       vld_u, tmo_u, err_u, vld_s, tmo_s, err_s;

  int cyc = 0;
  int rise_cyc = 0;
  int vld_cnt = 0, s_vld_cnt = 0, tmo_cnt = 0, s_tmo_cnt = 0;
  int err_cnt = 0, s_err_cnt = 0, lat = 0, s_lat = 0;
  logic [4:0] last_u = '0, last_s = '0;
  int n_vec = 0, n_bad = 0;

  pwm_demodulator #(.Size(5), .ClockPeriod_ns(20), .PWMPeriod_ns(10000),
                    .FilterCycles(3), .Signed("No")) dut_u (
    .Clock(clk), .Reset_n(rst_n), .PWM(pwm), .Sign(sgn),
    .Data(data_u), .Valid(vld_u), .Timeout(tmo_u), .Error(err_u));

  pwm_demodulator #(.Size(5), .ClockPeriod_ns(20), .PWMPeriod_ns(10000),
                    .FilterCycles(3), .Signed("Yes")) dut_s (
    .Clock(clk), .Reset_n(rst_n), .PWM(pwm), .Sign(sgn),
    .Data(data_s), .Valid(vld_s), .Timeout(tmo_s), .Error(err_s));

  always #10 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  always @(negedge clk) begin
    if (vld_u) begin
      vld_cnt++;
      last_u = data_u;
      lat = cyc - rise_cyc;
    end
    if (vld_s) begin
      s_vld_cnt++;
      last_s = data_s;
      s_lat = cyc - rise_cyc;
    end
    if (tmo_u) tmo_cnt++;
    if (tmo_s) s_tmo_cnt++;
    if (err_u) err_cnt++;
    if (err_s) s_err_cnt++;
  end

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0d, expected %0d", tag, got, exp);
    end
  endtask

  task automatic drive(input logic lvl, input int n);
    if (lvl && !pwm) rise_cyc = cyc;
    pwm = lvl;
    repeat (n) @(negedge clk);
  endtask

  // n periods of (h high, p-h low) then a short closing pulse whose edge
  // ends the last period
  task automatic send(input int h, input int p, input int n);
    for (int i = 0; i < n; i++) begin
      drive(1'b1, h);
      drive(1'b0, p - h);
    end
    drive(1'b1, 3);
    drive(1'b0, 20);
  endtask

  task automatic duty(input string tag, input int h, input int n, input logic s,
                      input int exp_u, input int exp_s);
    int v0, sv0, e0;
    sgn = s;
    v0 = vld_cnt; sv0 = s_vld_cnt; e0 = err_cnt;
    send(h, 500, n);
    chk({tag, "_vld"}, vld_cnt - v0, n);
    chk({tag, "_svld"}, s_vld_cnt - sv0, n);
    chk({tag, "_data"}, last_u, exp_u);
    chk({tag, "_sdata"}, last_s, exp_s);
    chk({tag, "_err"}, err_cnt - e0, 0);
  endtask

  task automatic lose_low(input string tag);
    int v0, t0;
    v0 = vld_cnt; t0 = tmo_cnt;
    drive(1'b0, 1100);
    chk({tag, "_tmo"}, tmo_cnt - t0, 1);
    chk({tag, "_vld"}, vld_cnt - v0, 1);
    chk({tag, "_data"}, last_u, 0);
  endtask

  initial begin
    int v0, sv0, t0, st0, e0, se0;

    repeat (3) @(negedge clk);
    chk("rst_data", data_u, 0);
    chk("rst_valid", vld_u, 0);
    chk("rst_timeout", tmo_u, 0);
    chk("rst_error", err_u, 0);
    chk("rst_sdata", data_s, 0);
    rst_n = 1'b1;
    drive(1'b0, 10);

    // 50% duty: 16 unsigned, -8 signed; result lands 11 cycles after the pin rise
    duty("half_neg", 250, 3, 1'b1, 16, 5'b11000);
    chk("lat_u", lat, 11);
    chk("lat_s", s_lat, 10);
    lose_low("low_a");

    duty("half_pos", 250, 2, 1'b0, 16, 8);
    lose_low("low_b");
    duty("quarter", 125, 3, 1'b0, 8, 4);
    lose_low("low_c");
    duty("near_full", 497, 2, 1'b0, 31, 15);
    lose_low("low_d");
    duty("min_width", 3, 2, 1'b0, 0, 0);
    lose_low("low_e");

    // Held high: timeout reports full scale
    v0 = vld_cnt; t0 = tmo_cnt; st0 = s_tmo_cnt;
    drive(1'b1, 1100);
    chk("hold_hi_tmo", tmo_cnt - t0, 1);
    chk("hold_hi_stmo", s_tmo_cnt - st0, 1);
    chk("hold_hi_vld", vld_cnt - v0, 1);
    chk("hold_hi_data", last_u, 31);
    chk("hold_hi_sdata", last_s, 15);
    drive(1'b0, 30);

    // Short third period is rejected and Data holds
    v0 = vld_cnt; e0 = err_cnt; se0 = s_err_cnt;
    drive(1'b1, 250); drive(1'b0, 250);
    drive(1'b1, 250); drive(1'b0, 250);
    drive(1'b1, 100); drive(1'b0, 100);
    drive(1'b1, 3);   drive(1'b0, 20);
    chk("badper_vld", vld_cnt - v0, 2);
    chk("badper_err", err_cnt - e0, 1);
    chk("badper_serr", s_err_cnt - se0, 1);
    chk("badper_data", data_u, 16);
    chk("badper_sdata", data_s, 8);
    lose_low("low_f");

    // Short glitches inside the high and low phases are filtered out
    v0 = vld_cnt; e0 = err_cnt;
    for (int i = 0; i < 2; i++) begin
      drive(1'b1, 100); drive(1'b0, 1); drive(1'b1, 149);
      drive(1'b0, 100); drive(1'b1, 2); drive(1'b0, 148);
    end
    drive(1'b1, 3); drive(1'b0, 20);
    chk("glitch_vld", vld_cnt - v0, 2);
    chk("glitch_err", err_cnt - e0, 0);
    chk("glitch_data", last_u, 16);
    lose_low("low_g");

    // Reset while the divider is running
    v0 = vld_cnt;
    drive(1'b1, 250); drive(1'b0, 250);
    drive(1'b1, 250); drive(1'b0, 250);
    drive(1'b1, 7);
    chk("prerst_data", data_u, 16);
    rst_n = 1'b0;
    pwm = 1'b0;
    #1;
    chk("midrst_data", data_u, 0);
    chk("midrst_valid", vld_u, 0);
    chk("midrst_timeout", tmo_u, 0);
    chk("midrst_error", err_u, 0);
    chk("midrst_sdata", data_s, 0);
    repeat (4) @(negedge clk);
    rst_n = 1'b1;
    drive(1'b0, 20);
    chk("midrst_vld", vld_cnt - v0, 1);
    v0 = vld_cnt; sv0 = s_vld_cnt;
    send(250, 500, 1);
    chk("postrst_vld", vld_cnt - v0, 1);
    chk("postrst_svld", s_vld_cnt - sv0, 1);
    chk("postrst_data", last_u, 16);

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
    $finish;
  end

endmodule
